// File: rtl/md_bus_pkg.sv
// Shared state encoding and cartridge address-map constants for the MD cart bus master.
package md_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_WAIT,
      ST_RECOVER
   } md_state_e;

   // Byte-address region boundaries decoded when a request is accepted
   localparam logic [15:0] TIME_BASE  = 16'hA130;
   localparam logic [23:0] CART_LIMIT = 24'h400000;
   localparam logic [23:0] ASEL_LIMIT = 24'h800000;

endpackage

// File: rtl/md_sync2.sv
// Two-flop synchroniser for an asynchronous active-low input; resets to the idle (high) level.
module md_sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         q_o    <= 1'b1;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/md_cart_bus_master.sv
// Cartridge-slot bus initiator: turns one-word core requests into sequenced, fully registered
// MD cart bus cycles and completes them on synchronised DTACK_N or on timeout.
module md_cart_bus_master
   import md_bus_pkg::*;
#(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned STROBE_MIN  = 2,
   parameter int unsigned TIMEOUT     = 64,
   parameter int unsigned RECOVER_CYC = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   // Handshake: REQ is held by the core until the one-cycle ACK pulse; the request is
   // accepted only in IDLE, and RDATA/ERR are valid while ACK is high.
   input  logic        REQ,
   input  logic [22:0] ADDR,
   input  logic [15:0] WDATA,
   input  logic        WE,
   input  logic [1:0]  BE,
   output logic        ACK,
   output logic [15:0] RDATA,
   output logic        ERR,
   output logic        BUSY,
   output logic [22:0] VA,
   output logic [15:0] VDO,
   output logic        VDO_OE,
   input  logic [15:0] VDI,
   output logic        AS_N,
   output logic        CAS0_N,
   output logic        LWR_N,
   output logic        UWR_N,
   output logic        CE0_N,
   output logic        TIME_N,
   output logic        ASEL_N,
   input  logic        DTACK_N,
   output md_state_e   DBG_STATE
);

   localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD  = 4'(STROBE_MIN - 1);
   localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);
   localparam logic [7:0] TOUT_LAST  = 8'(TIMEOUT - 1);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  tcnt_q, tcnt_d;
   logic        we_q, we_d;
   logic [1:0]  be_q, be_d;
   logic [22:0] va_q, va_d;
   logic [15:0] vdo_q, vdo_d;
   logic        vdo_oe_q, vdo_oe_d;
   logic        as_n_q, as_n_d, cas0_n_q, cas0_n_d, lwr_n_q, lwr_n_d, uwr_n_q, uwr_n_d;
   logic        ce0_n_q, ce0_n_d, time_n_q, time_n_d, asel_n_q, asel_n_d;
   logic        ack_q, ack_d, err_q, err_d, busy_q, busy_d;
   logic [15:0] rdata_q, rdata_d;
   logic        dts;
   logic [23:0] byte_addr;

   md_sync2 u_dtack_sync (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .d_i    (DTACK_N),
      .q_o    (dts)
   );

   assign byte_addr = {ADDR, 1'b0};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tcnt_d   = tcnt_q;
      we_d     = we_q;
      be_d     = be_q;
      va_d     = va_q;
      vdo_d    = vdo_q;
      vdo_oe_d = vdo_oe_q;
      as_n_d   = as_n_q;
      cas0_n_d = cas0_n_q;
      lwr_n_d  = lwr_n_q;
      uwr_n_d  = uwr_n_q;
      ce0_n_d  = ce0_n_q;
      time_n_d = time_n_q;
      asel_n_d = asel_n_q;
      ack_d    = 1'b0;
      err_d    = err_q;
      rdata_d  = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (REQ) begin
               we_d     = WE;
               be_d     = (BE == 2'b00) ? 2'b11 : BE;
               va_d     = ADDR;
               vdo_d    = WDATA;
               vdo_oe_d = WE;
               ce0_n_d  = !(byte_addr < CART_LIMIT);
               time_n_d = !(byte_addr[23:8] == TIME_BASE);
               asel_n_d = !(byte_addr < ASEL_LIMIT);
               cnt_d    = SETUP_LD;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == 4'd0) begin
               as_n_d = 1'b0;
               if (we_q) begin
                  uwr_n_d = !be_q[1];
                  lwr_n_d = !be_q[0];
               end else begin
                  cas0_n_d = 1'b0;
               end
               cnt_d   = STROBE_LD;
               state_d = ST_STROBE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == 4'd0) begin
               tcnt_d  = 8'd0;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_WAIT: begin
            // A live DTACK wins over a timeout landing on the same edge
            if (!dts || (tcnt_q == TOUT_LAST)) begin
               ack_d    = 1'b1;
               err_d    = dts;
               if (!we_q) rdata_d = VDI;
               as_n_d   = 1'b1;
               cas0_n_d = 1'b1;
               lwr_n_d  = 1'b1;
               uwr_n_d  = 1'b1;
               vdo_oe_d = 1'b0;
               cnt_d    = RECOVER_LD;
               state_d  = ST_RECOVER;
            end else begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == 4'd0) begin
               ce0_n_d  = 1'b1;
               time_n_d = 1'b1;
               asel_n_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         tcnt_q   <= '0;
         we_q     <= 1'b0;
         be_q     <= 2'b00;
         va_q     <= '0;
         vdo_q    <= '0;
         vdo_oe_q <= 1'b0;
         as_n_q   <= 1'b1;
         cas0_n_q <= 1'b1;
         lwr_n_q  <= 1'b1;
         uwr_n_q  <= 1'b1;
         ce0_n_q  <= 1'b1;
         time_n_q <= 1'b1;
         asel_n_q <= 1'b1;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tcnt_q   <= tcnt_d;
         we_q     <= we_d;
         be_q     <= be_d;
         va_q     <= va_d;
         vdo_q    <= vdo_d;
         vdo_oe_q <= vdo_oe_d;
         as_n_q   <= as_n_d;
         cas0_n_q <= cas0_n_d;
         lwr_n_q  <= lwr_n_d;
         uwr_n_q  <= uwr_n_d;
         ce0_n_q  <= ce0_n_d;
         time_n_q <= time_n_d;
         asel_n_q <= asel_n_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         rdata_q  <= rdata_d;
      end
   end

   assign ACK       = ack_q;
   assign RDATA     = rdata_q;
   assign ERR       = err_q;
   assign BUSY      = busy_q;
   assign VA        = va_q;
   assign VDO       = vdo_q;
   assign VDO_OE    = vdo_oe_q;
   assign AS_N      = as_n_q;
   assign CAS0_N    = cas0_n_q;
   assign LWR_N     = lwr_n_q;
   assign UWR_N     = uwr_n_q;
   assign CE0_N     = ce0_n_q;
   assign TIME_N    = time_n_q;
   assign ASEL_N    = asel_n_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_md_cart_bus_master.sv
// Randomised self-checking bench for md_cart_bus_master against a cycle-count reference model.
module tb_md_cart_bus_master;
   import md_bus_pkg::*;

   localparam int S_CYC = 2;
   localparam int ST_MIN = 2;
   localparam int TOUT = 64;
   localparam int R_CYC = 1;

   logic        CLK, RST_N, REQ, WE, ACK, ERR, BUSY, VDO_OE, DTACK_N;
   logic [22:0] ADDR, VA;
   logic [15:0] WDATA, RDATA, VDO, VDI;
   logic [1:0]  BE;
   logic        AS_N, CAS0_N, LWR_N, UWR_N, CE0_N, TIME_N, ASEL_N;
   md_state_e   dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_ack_cyc = 0;
   logic [15:0] model_rdata = 16'h0000;
   logic [16:0] exp_q[$];

   md_cart_bus_master #(
      .SETUP_CYC(S_CYC), .STROBE_MIN(ST_MIN), .TIMEOUT(TOUT), .RECOVER_CYC(R_CYC)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .ADDR(ADDR), .WDATA(WDATA), .WE(WE), .BE(BE),
      .ACK(ACK), .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY), .VA(VA), .VDO(VDO), .VDO_OE(VDO_OE),
      .VDI(VDI), .AS_N(AS_N), .CAS0_N(CAS0_N), .LWR_N(LWR_N), .UWR_N(UWR_N),
      .CE0_N(CE0_N), .TIME_N(TIME_N), .ASEL_N(ASEL_N), .DTACK_N(DTACK_N), .DBG_STATE(dbg_state)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // dmode: 0 = DTACK_N low before the cycle, 1 = never acknowledged, 2 = DTACK_N falls dk edges after acceptance
   task automatic run_txn(input logic [22:0] addr, input logic we, input logic [1:0] be,
                          input logic [15:0] wdata, input logic [15:0] vdi,
                          input int dmode, input int dk, input bit b2b, input bit hold, input bit drop);
      logic [23:0] ba;
      logic [1:0]  eff_be;
      logic [2:0]  exp_sel;
      logic [16:0] exp_v;
      int exp_lat, as_edge, ack_edge;
      ba = {addr, 1'b0};
      eff_be = (be == 2'b00) ? 2'b11 : be;
      exp_sel = {!(ba < 24'h400000), !(ba[23:8] == 16'hA130), !(ba < 24'h800000)};
      if (dmode == 0) exp_lat = S_CYC + ST_MIN + 1;
      else if (dmode == 1) exp_lat = S_CYC + ST_MIN + TOUT;
      else exp_lat = (dk + 3 > S_CYC + ST_MIN + 1) ? dk + 3 : S_CYC + ST_MIN + 1;
      if (!we) model_rdata = vdi;
      exp_q.push_back({dmode == 1, model_rdata});

      @(negedge CLK);
      if (!b2b) begin
         DTACK_N = (dmode == 0) ? 1'b0 : 1'b1;
         repeat (3) @(negedge CLK);
      end
      ADDR = addr; WE = we; BE = be; WDATA = wdata; VDI = vdi; REQ = 1'b1;
      @(posedge CLK); #1;
      check("acc_busy", BUSY, 1);
      check("acc_va", VA, addr);
      check("acc_sel", {CE0_N, TIME_N, ASEL_N}, exp_sel);
      check("acc_oe_as", {VDO_OE, AS_N}, {we, 1'b1});

      as_edge = -1;
      ack_edge = -1;
      for (int e = 1; e <= 200 && ack_edge < 0; e++) begin
         @(negedge CLK);
         if (dmode == 2 && e - 1 == dk) DTACK_N = 1'b0;
         if (drop && e == 2) REQ = 1'b0;
         @(posedge CLK); #1;
         if (AS_N == 1'b0 && as_edge < 0) begin
            as_edge = e;
            if (b2b) check("b2b_gap", cyc - last_ack_cyc, R_CYC + 1 + S_CYC);
            check("strobe", {CAS0_N, UWR_N, LWR_N}, {we, !(we && eff_be[1]), !(we && eff_be[0])});
            check("strobe_oe", VDO_OE, we);
            if (we) check("strobe_vdo", VDO, wdata);
            check("strobe_sel", {CE0_N, TIME_N, ASEL_N}, exp_sel);
         end
         if (ACK) begin
            ack_edge = e;
            last_ack_cyc = cyc;
         end
      end
      exp_v = exp_q.pop_front();
      if (ack_edge < 0) begin
         check("ack_seen", 0, 1);
      end else begin
         check("as_fall_edge", as_edge, S_CYC);
         check("ack_latency", ack_edge, exp_lat);
         check("ack_data", {ERR, RDATA}, exp_v);
         check("ack_strobes_off", {AS_N, CAS0_N, UWR_N, LWR_N, VDO_OE}, 5'b11110);
         check("ack_va", VA, addr);
         @(negedge CLK);
         if (!hold) begin
            REQ = 1'b0;
            DTACK_N = 1'b1;
         end
         @(posedge CLK); #1;
         check("ack_pulse", ACK, 0);
         check("rec_busy", BUSY, 0);
         check("rec_sel", {CE0_N, TIME_N, ASEL_N}, 3'b111);
      end
   endtask

   function automatic logic [22:0] rand_addr();
      case ($urandom_range(0, 3))
         0: rand_addr = 23'($urandom_range(0, 23'h1FFFFF));
         1: rand_addr = 23'($urandom_range(23'h200000, 23'h3FFFFF));
         2: rand_addr = 23'($urandom_range(23'h400000, 23'h7FFFFF));
         default: rand_addr = {16'hA130, 7'($urandom_range(0, 127))};
      endcase
   endfunction

   int acks_seen;
   int r;

   initial begin
      RST_N = 1'b0; REQ = 1'b0; ADDR = '0; WDATA = '0; WE = 1'b0; BE = 2'b00;
      VDI = '0; DTACK_N = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_n_outs", {AS_N, CAS0_N, LWR_N, UWR_N, CE0_N, TIME_N, ASEL_N}, 7'h7F);
      check("rst_bus", {VA, VDO, VDO_OE}, 0);
      check("rst_status", {ACK, ERR, BUSY, RDATA}, 0);
      check("rst_state", dbg_state, ST_IDLE);
      RST_N = 1'b1;

      // directed cases from the bring-up plan
      run_txn(23'h000100, 1'b0, 2'b11, 16'h0000, 16'h4E71, 0, 0, 0, 0, 0);
      run_txn(23'h509878, 1'b1, 2'b01, 16'h0001, 16'hDEAD, 0, 0, 0, 0, 0);
      run_txn(23'h100000, 1'b0, 2'b11, 16'h0000, 16'hBEEF, 1, 0, 0, 0, 0);
      run_txn(23'h000180, 1'b1, 2'b00, 16'h1234, 16'h5555, 2, 7, 0, 0, 0);
      run_txn(23'h000200, 1'b0, 2'b11, 16'h0000, 16'hA5A5, 0, 0, 0, 1, 0);
      run_txn(23'h000201, 1'b0, 2'b11, 16'h0000, 16'h5A5A, 0, 0, 1, 0, 0);

      // reset pulse while waiting on an unacknowledging cart
      @(negedge CLK);
      DTACK_N = 1'b1;
      repeat (3) @(negedge CLK);
      ADDR = 23'h000300; WE = 1'b0; BE = 2'b11; REQ = 1'b1;
      repeat (10) @(posedge CLK);
      #3 RST_N = 1'b0;
      #1;
      check("mid_rst_n_outs", {AS_N, CAS0_N, LWR_N, UWR_N, CE0_N, TIME_N, ASEL_N}, 7'h7F);
      check("mid_rst_status", {ACK, BUSY}, 0);
      check("mid_rst_state", dbg_state, ST_IDLE);
      REQ = 1'b0;
      model_rdata = 16'h0000;
      @(negedge CLK);
      RST_N = 1'b1;
      acks_seen = 0;
      repeat (80) begin
         @(posedge CLK); #1;
         if (ACK) acks_seen++;
      end
      check("mid_rst_no_ack", acks_seen, 0);
      run_txn(23'h000301, 1'b1, 2'b10, 16'hCAFE, 16'h0F0F, 0, 0, 0, 0, 0);

      // randomised traffic
      for (int i = 0; i < 24; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            run_txn(rand_addr(), 1'b0, 2'b11, 16'h0, 16'($urandom), 0, 0, 0, 1, 0);
            run_txn(rand_addr(), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 0, 0, 1, 0, 0);
         end else begin
            run_txn(rand_addr(), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                    (r <= 5) ? 0 : ((r <= 8) ? 2 : 1), $urandom_range(0, 40), 0, 0,
                    $urandom_range(0, 3) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
